// File: rtl/pixel_scan_pkg.sv
// Shared types and default screen geometry for the pixel scan controller.
package pixel_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;

endpackage

// File: rtl/pixel_scan_ctrl_if.sv
// Pixel coordinate stream between the scan controller and the downstream queue.
// Handshake: a coordinate transfers in a cycle where pixel_valid=1 and
// full_queue=0; while full_queue=1 the producer holds pixel_x/pixel_y stable.
interface pixel_scan_ctrl_if #(
  parameter int PIXEL_DATA_WIDTH = 10
);
  logic [PIXEL_DATA_WIDTH-1:0] pixel_x;
  logic [PIXEL_DATA_WIDTH-1:0] pixel_y;
  logic                        pixel_valid;
  logic                        full_queue;

  modport master (output pixel_x, output pixel_y, output pixel_valid, input full_queue);
  modport slave  (input pixel_x, input pixel_y, input pixel_valid, output full_queue);
endinterface

// File: rtl/pixel_coord_counter.sv
// Raster x/y counter: x runs 0..W-1, then y steps; the last pixel wraps to (0,0).
module pixel_coord_counter #(
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        advance,
  output logic [PIXEL_DATA_WIDTH-1:0] x,
  output logic [PIXEL_DATA_WIDTH-1:0] y,
  output logic                        last
);
  localparam logic [PIXEL_DATA_WIDTH-1:0] X_MAX = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_MAX = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

  logic [PIXEL_DATA_WIDTH-1:0] r_x;
  logic [PIXEL_DATA_WIDTH-1:0] r_y;
  logic                        w_x_end;

  assign w_x_end = (r_x == X_MAX);
  assign last    = w_x_end && (r_y == Y_MAX);
  assign x       = r_x;
  assign y       = r_y;

  // Step the raster position on each accepted pixel; clear restarts the frame.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (advance) begin
      if (!w_x_end) begin
        r_x <= r_x + 1'b1;
      end else begin
        r_x <= '0;
        r_y <= last ? '0 : r_y + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pixel_scan_ctrl.sv
// Frame scan controller: latches zoom/pan once per frame, then walks every
// screen coordinate through a valid/full_queue stream.
// Optional macro PIXEL_SCAN_AUTO_RESTART_EN: DONE loops straight back to LATCH
// for continuous frames instead of waiting in IDLE for start.
module pixel_scan_ctrl
  import pixel_scan_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH  = 10,
  parameter int ENGINE_DATA_WIDTH = 25,
  parameter int SCREEN_WIDTH      = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT     = DEF_SCREEN_HEIGHT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [2:0]                          zoom_in,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] x_offset_in,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] y_offset_in,
  pixel_scan_ctrl_if.master                   pix,
  output logic [2:0]                          zoom,
  output logic signed [ENGINE_DATA_WIDTH-1:0] x_offset,
  output logic signed [ENGINE_DATA_WIDTH-1:0] y_offset,
  output logic                                busy,
  output logic                                frame_done,
  output state_e                              o_dbg_state
);
  state_e                              r_state;
  state_e                              w_next;
  logic                                w_accept;
  logic                                w_last;
  logic [PIXEL_DATA_WIDTH-1:0]         w_x;
  logic [PIXEL_DATA_WIDTH-1:0]         w_y;
  logic [2:0]                          r_zoom;
  logic signed [ENGINE_DATA_WIDTH-1:0] r_x_offset;
  logic signed [ENGINE_DATA_WIDTH-1:0] r_y_offset;

  assign w_accept = (r_state == ST_SCAN) && !pix.full_queue;

  pixel_coord_counter #(
    .PIXEL_DATA_WIDTH(PIXEL_DATA_WIDTH),
    .SCREEN_WIDTH    (SCREEN_WIDTH),
    .SCREEN_HEIGHT   (SCREEN_HEIGHT)
  ) u_coord (
    .clk    (clk),
    .reset  (reset),
    .clear  (r_state == ST_LATCH),
    .advance(w_accept),
    .x      (w_x),
    .y      (w_y),
    .last   (w_last)
  );

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; start only matters while idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LATCH;
      ST_LATCH: w_next = ST_SCAN;
      ST_SCAN:  if (w_accept && w_last) w_next = ST_DONE;
`ifdef PIXEL_SCAN_AUTO_RESTART_EN
      ST_DONE:  w_next = ST_LATCH;
`else
      ST_DONE:  w_next = ST_IDLE;
`endif
      default:  w_next = ST_IDLE;
    endcase
  end

  // Frame parameters are captured only in LATCH and held for the whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_zoom     <= '0;
      r_x_offset <= '0;
      r_y_offset <= '0;
    end else if (r_state == ST_LATCH) begin
      r_zoom     <= zoom_in;
      r_x_offset <= x_offset_in;
      r_y_offset <= y_offset_in;
    end
  end

  assign pix.pixel_x     = w_x;
  assign pix.pixel_y     = w_y;
  assign pix.pixel_valid = (r_state == ST_SCAN);
  assign zoom            = r_zoom;
  assign x_offset        = r_x_offset;
  assign y_offset        = r_y_offset;
  assign busy            = (r_state != ST_IDLE);
  assign frame_done      = (r_state == ST_DONE);
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Self-checking bench for pixel_scan_ctrl on a 4x3 screen.
module tb_pixel_scan_ctrl;
  import pixel_scan_pkg::*;

  localparam int PDW = 10;
  localparam int EDW = 25;
  localparam int W   = 4;
  localparam int H   = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [2:0]            zoom_in;
  logic signed [EDW-1:0] x_offset_in;
  logic signed [EDW-1:0] y_offset_in;
  logic [2:0]            zoom;
  logic signed [EDW-1:0] x_offset;
  logic signed [EDW-1:0] y_offset;
  logic                  busy;
  logic                  frame_done;
  state_e                dbg_state;

  pixel_scan_ctrl_if #(.PIXEL_DATA_WIDTH(PDW)) pix ();

  pixel_scan_ctrl #(
    .PIXEL_DATA_WIDTH (PDW),
    .ENGINE_DATA_WIDTH(EDW),
    .SCREEN_WIDTH     (W),
    .SCREEN_HEIGHT    (H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .zoom_in    (zoom_in),
    .x_offset_in(x_offset_in),
    .y_offset_in(y_offset_in),
    .pix        (pix.master),
    .zoom       (zoom),
    .x_offset   (x_offset),
    .y_offset   (y_offset),
    .busy       (busy),
    .frame_done (frame_done),
    .o_dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*PDW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic randomize_inputs();
    zoom_in     = 3'($urandom_range(0, 7));
    x_offset_in = EDW'($urandom);
    y_offset_in = EDW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_x"},     32'(pix.pixel_x), 0);
    chk({tag, "_y"},     32'(pix.pixel_y), 0);
    chk({tag, "_valid"}, 32'(pix.pixel_valid), 0);
    chk({tag, "_zoom"},  32'(zoom), 0);
    chk({tag, "_xoff"},  32'(x_offset), 0);
    chk({tag, "_yoff"},  32'(y_offset), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(frame_done), 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic do_reset(input bit with_start);
    @(negedge clk);
    reset = 1'b1;
    start = with_start;
    randomize_inputs();
    pix.full_queue = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    pix.full_queue = 1'b0;
    check_all_zero("reset");
  endtask

  // mode 0: no stalls; 1: five-cycle stall at (2,1); 2: random stalls plus a
  // stall on the last pixel; 3: reset asserted when (1,1) is presented.
  task automatic run_frame(input int mode, input logic [2:0] z);
    logic [2:0]            ez;
    logic signed [EDW-1:0] ex;
    logic signed [EDW-1:0] ey;
    logic [PDW-1:0]        hx;
    logic [PDW-1:0]        hy;
    int  k;
    int  stalls;
    int  held;
    bit  done;
    bit  fq;
    ez = z;
    ex = EDW'($urandom);
    ey = EDW'($urandom);
    k = 0; stalls = 0; held = 0; done = 1'b0;
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({PDW'(y), PDW'(x)});

    @(negedge clk);
    start = 1'b1; zoom_in = ez; x_offset_in = ex; y_offset_in = ey;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("latch_busy", 32'(busy), 1);
    chk("latch_valid", 32'(pix.pixel_valid), 0);

    while (!done && k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      chk("hold_zoom", 32'(zoom), 32'(ez));
      chk("hold_xoff", 32'(x_offset), 32'(ex));
      chk("hold_yoff", 32'(y_offset), 32'(ey));
      if (frame_done) begin
        done = 1'b1;
        chk("done_latency", k, W * H + 1 + stalls);
        chk("done_q_empty", exp_q.size(), 0);
        chk("done_wrap_x", 32'(pix.pixel_x), 0);
        chk("done_wrap_y", 32'(pix.pixel_y), 0);
        start = 1'b0;
        pix.full_queue = 1'b0;
      end else begin
        chk("scan_valid", 32'(pix.pixel_valid), 1);
        chk("scan_busy", 32'(busy), 1);
        if (exp_q.size() == 0) begin
          chk("extra_pixel", 0, 1);
          done = 1'b1;
        end else begin
          hy = exp_q[0][2*PDW-1:PDW];
          hx = exp_q[0][PDW-1:0];
          chk("pix_x", 32'(pix.pixel_x), 32'(hx));
          chk("pix_y", 32'(pix.pixel_y), 32'(hy));
          if (mode == 3 && hx == 1 && hy == 1) begin
            reset = 1'b1;
            pix.full_queue = 1'b0;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            check_all_zero("abort");
            for (int i = 0; i < 4; i++) begin
              @(posedge clk);
              @(negedge clk);
              chk("abort_no_done", 32'(frame_done), 0);
              chk("abort_idle", 32'(busy), 0);
            end
            return;
          end
          fq = 1'b0;
          if (mode == 1 && hx == 2 && hy == 1 && held < 5) begin
            fq = 1'b1; held++;
          end else if (mode == 2) begin
            if (exp_q.size() == 1 && held < 3) begin
              fq = 1'b1; held++;
            end else begin
              fq = ($urandom_range(0, 2) == 0);
            end
          end
          if (fq) stalls++;
          else    void'(exp_q.pop_front());
          pix.full_queue = fq;
          randomize_inputs();
          start = ($urandom_range(0, 3) == 0);
        end
      end
    end
    if (!done) chk("frame_timeout", 0, 1);
    start = 1'b0;
    pix.full_queue = 1'b0;

`ifdef PIXEL_SCAN_AUTO_RESTART_EN
    @(posedge clk);
    @(negedge clk);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_latch_valid", 32'(pix.pixel_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("restart_valid", 32'(pix.pixel_valid), 1);
    chk("restart_x", 32'(pix.pixel_x), 0);
    chk("restart_y", 32'(pix.pixel_y), 0);
    do_reset(1'b0);
`else
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("after_busy", 32'(busy), 0);
      chk("after_done", 32'(frame_done), 0);
      chk("after_valid", 32'(pix.pixel_valid), 0);
      chk("after_zoom", 32'(zoom), 32'(ez));
      randomize_inputs();
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    zoom_in = '0;
    x_offset_in = '0;
    y_offset_in = '0;
    pix.full_queue = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    run_frame(0, 3'd3);
    run_frame(1, 3'($urandom_range(0, 7)));
    for (int i = 0; i < 3; i++) run_frame(2, 3'($urandom_range(0, 7)));
    run_frame(3, 3'($urandom_range(0, 7)));
    do_reset(1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("reset_beats_start", 32'(busy), 0);
    run_frame(0, 3'($urandom_range(0, 7)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pixel_scan_ctrl.md
PIXEL_SCAN_CTRL -- requirements
Module: pixel_scan_ctrl

Interface
REQ-001 SHALL have parameter PIXEL_DATA_WIDTH, default 10, width of pixel coordinates.
REQ-002 SHALL have parameter ENGINE_DATA_WIDTH, default 25, width of signed fixed-point offsets.
REQ-003 SHALL have parameter SCREEN_WIDTH, default 640, pixels per line.
REQ-004 SHALL have parameter SCREEN_HEIGHT, default 480, lines per frame.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, request one frame scan.
REQ-009 SHALL have port full_queue, input, 1, downstream backpressure.
REQ-010 SHALL have port zoom_in, input, 3, requested zoom level.
REQ-011 SHALL have ports x_offset_in and y_offset_in, input, ENGINE_DATA_WIDTH signed, requested pan.
REQ-012 SHALL have ports pixel_x and pixel_y, output, PIXEL_DATA_WIDTH, current coordinate.
REQ-013 SHALL have port pixel_valid, output, 1, coordinate presented.
REQ-014 SHALL have port zoom, output, 3, frame-latched zoom.
REQ-015 SHALL have ports x_offset and y_offset, output, ENGINE_DATA_WIDTH signed, frame-latched pan.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port frame_done, output, 1, single-cycle end-of-frame pulse.

Function
REQ-018 SHALL implement the states IDLE, LATCH, SCAN and DONE.
REQ-019 In IDLE with start=1, SHALL go to LATCH next cycle; start SHALL be ignored in all other states.
REQ-020 LATCH SHALL last exactly one cycle, register zoom_in, x_offset_in and y_offset_in into zoom, x_offset and y_offset, clear pixel_x/pixel_y to 0, then go to SCAN.
REQ-021 zoom and offset outputs SHALL stay constant from LATCH until the next LATCH, unaffected by input changes mid-frame.
REQ-022 pixel_valid SHALL be 1 exactly while in SCAN.
REQ-023 A pixel SHALL be accepted in a cycle with pixel_valid=1 and full_queue=0; pixel_x/pixel_y SHALL hold while full_queue=1.
REQ-024 On accept: pixel_x<SCREEN_WIDTH-1 -> pixel_x+1; else pixel_x->0 and pixel_y+1.
REQ-025 On accept of (SCREEN_WIDTH-1, SCREEN_HEIGHT-1), SHALL go to DONE; coordinates SHALL wrap to (0,0).
REQ-026 DONE SHALL last one cycle with frame_done=1, then go to IDLE.
REQ-027 Throughput SHALL be one pixel per cycle without backpressure; frame from start to frame_done is 1+1+W*H+1 cycles plus stall cycles.
REQ-028 full_queue asserted on the last pixel SHALL delay DONE until it is accepted.

Reset
REQ-029 reset SHALL take priority over all inputs and place the block in IDLE next edge.
REQ-030 After reset: pixel_x=0, pixel_y=0, pixel_valid=0, zoom=0, x_offset=0, y_offset=0, busy=0, frame_done=0.
REQ-031 Reset mid-SCAN SHALL abandon the frame with no frame_done pulse.

Configuration
REQ-032 Macro PIXEL_SCAN_AUTO_RESTART_EN: when defined, DONE SHALL go to LATCH instead of IDLE (continuous frames, new zoom/offset sampled each frame); when undefined, DONE SHALL go to IDLE and await start.

Structure
REQ-033 Package pixel_scan_pkg SHALL hold the state enum type and default screen-dimension constants.
REQ-034 The x/y wrap counter SHALL be sub-module pixel_coord_counter (inputs: clear, advance; outputs: x, y, last).

Verification
REQ-035 Reset, then start pulse, full_queue=0, W=4, H=3 -> 12 consecutive valid coordinates (0,0)..(3,2), frame_done on cycle 15 after start.
REQ-036 full_queue=1 for 5 cycles at (2,1) -> pixel_x/pixel_y hold at (2,1); frame_done delayed by exactly 5 cycles.
REQ-037 zoom_in 3->5 and x_offset_in changed during SCAN -> zoom stays 3 and x_offset unchanged until the next LATCH.
REQ-038 start pulsed during SCAN -> ignored; one frame_done only, then busy=0 (macro undefined).
REQ-039 reset asserted at (1,1) -> next cycle IDLE, all outputs 0, no frame_done.
REQ-040 With PIXEL_SCAN_AUTO_RESTART_EN defined -> after frame_done, LATCH follows immediately and the second frame begins at (0,0) without start.
